// File: rtl/seq_div_unit.sv
// seq_div_unit: multi-cycle radix-2 restoring divider
// signed/unsigned per operation, valid/ready on both sides
module seq_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divide_by_0
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_b_zero;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_keep;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_q_nx;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign in_ready = (r_state == S_IDLE);

  // operand conditioning: magnitudes only matter in signed mode
  always_comb begin
    w_neg_a  = signed_op & a[WIDTH-1];
    w_neg_b  = signed_op & b[WIDTH-1];
    w_abs_a  = w_neg_a ? (~a + 1'b1) : a;
    w_abs_b  = w_neg_b ? (~b + 1'b1) : b;
    w_b_zero = (b == '0);
  end

  // one restoring step: the quotient bit enters where the
  // consumed dividend bit left
  always_comb begin
    w_shift  = {r_rem, r_dvd[WIDTH-1]};
    w_diff   = w_shift - {1'b0, r_dvs};
    w_keep   = ~w_diff[WIDTH];
    w_rem_nx = w_keep ? w_diff[WIDTH-1:0]
                      : w_shift[WIDTH-1:0];
    w_q_nx   = {r_dvd[WIDTH-2:0], w_keep};
    w_q_fix  = r_neg_q ? (~w_q_nx + 1'b1) : w_q_nx;
    w_r_fix  = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;
  end

  // control FSM with registered datapath and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      divide_by_0 <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_b_zero) begin
              quotient    <= '1;
              remainder   <= a;
              divide_by_0 <= 1'b1;
              out_valid   <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_dvd   <= w_abs_a;
              r_dvs   <= w_abs_b;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_neg_q <= w_neg_a ^ w_neg_b;
              r_neg_r <= w_neg_a;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_dvd <= w_q_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            quotient    <= w_q_fix;
            remainder   <= w_r_fix;
            divide_by_0 <= 1'b0;
            out_valid   <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_unit.sv
// tb_seq_div_unit: directed and randomized checks of seq_div_unit
// against an arithmetic reference model
module tb_seq_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divide_by_0;

  int checks = 0;
  int fails  = 0;

  seq_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .signed_op(signed_op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .divide_by_0(divide_by_0)
  );

  always #5 clk = ~clk;

  function automatic void model(
    input  logic [31:0] ma, mb,
    input  bit          ms,
    output logic [31:0] q, r,
    output logic        z
  );
    longint sa, sb, q64, r64;
    if (mb == 0) begin
      q = '1; r = ma; z = 1'b1;
    end else begin
      sa = ms ? {{32{ma[31]}}, ma} : {32'b0, ma};
      sb = ms ? {{32{mb[31]}}, mb} : {32'b0, mb};
      q64 = sa / sb;
      r64 = sa % sb;
      q = q64[31:0]; r = r64[31:0]; z = 1'b0;
    end
  endfunction

  // lat counts edges from the cycle in_valid is presented;
  // the accept edge is 1
  task automatic run_op(
    input  logic [31:0] ta, tb_,
    input  bit          ts,
    output logic [31:0] q, r,
    output logic        z,
    output int          lat
  );
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    a = ta; b = tb_; signed_op = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    signed_op = 1'($urandom_range(0, 1));
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    q = quotient; r = remainder; z = divide_by_0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 32'd9; b = 32'd3; signed_op = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || quotient !== 32'd0 ||
        remainder !== 32'd0 || divide_by_0 !== 1'b0 ||
        in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: ov=%b q=%h r=%h z=%b rdy=%b required 0 0 0 0 1",
               out_valid, quotient, remainder, divide_by_0, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_hold: ov=%b rdy=%b required 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vq[6];
    logic [31:0] vr[6];
    logic [31:0] va[6];
    logic [31:0] vb[6];
    bit          vs[6];
    logic        vz[6];
    int          vl[6];
    logic [31:0] q, r;
    logic        z;
    int          lat;
    va = '{32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9,
           32'd5, 32'hFFFFFFFB, 32'h80000000};
    vb = '{32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF};
    vs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vq = '{32'd14, 32'hFFFFFFFD, 32'h7FFFFFFC,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    vr = '{32'd2, 32'hFFFFFFFF, 32'd1,
           32'd5, 32'hFFFFFFFB, 32'd0};
    vz = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vl = '{33, 33, 33, 1, 1, 33};
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vs[i], q, r, z, lat);
      checks++;
      if (q !== vq[i] || r !== vr[i] || z !== vz[i]) begin
        fails++;
        $display("FAIL directed%0d: q=%h r=%h z=%b required q=%h r=%h z=%b",
                 i, q, r, z, vq[i], vr[i], vz[i]);
      end
      checks++;
      if (lat !== vl[i]) begin
        fails++;
        $display("FAIL latency%0d: got %0d required %0d",
                 i, lat, vl[i]);
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL consume%0d: ov=%b rdy=%b required 0 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, q, r, eq, er;
    logic        z, ez;
    bit          rs;
    int          lat;
    int          sel;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel < 3) rb = 32'($urandom_range(1, 20));
      else if (sel == 3) rb = -32'($urandom_range(1, 20));
      else rb = $urandom;
      if (sel == 7) begin
        ra = 32'h80000000; rb = 32'hFFFFFFFF;
      end
      if (sel == 6) ra = ra >> $urandom_range(0, 31);
      model(ra, rb, rs, eq, er, ez);
      run_op(ra, rb, rs, q, r, z, lat);
      checks++;
      if (q !== eq || r !== er || z !== ez ||
          lat !== (ez ? 1 : 33)) begin
        fails++;
        $display("FAIL random%0d a=%h b=%h s=%b: q=%h r=%h z=%b lat=%0d required q=%h r=%h z=%b lat=%0d",
                 i, ra, rb, rs, q, r, z, lat, eq, er, ez,
                 ez ? 1 : 33);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] q0, r0, eq, er;
    logic        ez;
    int          lat;
    bit          stable;
    while (!in_ready) begin
      @(posedge clk); #1;
    end
    a = 32'd1000; b = 32'd3; signed_op = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    q0 = quotient; r0 = remainder;
    checks++;
    if (q0 !== 32'd333 || r0 !== 32'd1 || lat !== 33) begin
      fails++;
      $display("FAIL bp_first: q=%h r=%h lat=%0d required 14d 1 33",
               q0, r0, lat);
    end
    a = 32'd77777; b = 32'd123; signed_op = 1'b0;
    in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (quotient !== q0 || remainder !== r0 ||
          divide_by_0 !== 1'b0 || out_valid !== 1'b1 ||
          in_ready !== 1'b0)
        stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      fails++;
      $display("FAIL bp_hold: q=%h r=%h ov=%b rdy=%b required %h %h 1 0",
               quotient, remainder, out_valid, in_ready, q0, r0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: ov=%b rdy=%b required 0 1",
               out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept: rdy=%b required 0", in_ready);
    end
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    model(32'd77777, 32'd123, 1'b0, eq, er, ez);
    checks++;
    if (quotient !== eq || remainder !== er ||
        divide_by_0 !== ez || lat !== 33) begin
      fails++;
      $display("FAIL bp_second: q=%h r=%h lat=%0d required %h %h 33",
               quotient, remainder, lat, eq, er);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r;
    logic        z;
    int          lat;
    bit          saw = 1'b0;
    while (!in_ready) begin
      @(posedge clk); #1;
    end
    a = 32'd12345; b = 32'd7; signed_op = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      saw |= out_valid;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || quotient !== 32'd0 ||
        remainder !== 32'd0 || divide_by_0 !== 1'b0 ||
        in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst: ov=%b q=%h r=%h z=%b rdy=%b required 0 0 0 0 1",
               out_valid, quotient, remainder, divide_by_0, in_ready);
    end
    repeat (40) begin
      @(posedge clk); #1;
      saw |= out_valid;
    end
    checks++;
    if (saw) begin
      fails++;
      $display("FAIL midrst_pulse: out_valid seen 1 required 0");
    end
    run_op(32'd1000, 32'd10, 1'b0, q, r, z, lat);
    checks++;
    if (q !== 32'd100 || r !== 32'd0 || z !== 1'b0 || lat !== 33) begin
      fails++;
      $display("FAIL midrst_after: q=%h r=%h z=%b lat=%0d required 64 0 0 33",
               q, r, z, lat);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    signed_op = 1'b0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
